// File: rtl/pipe_chain.sv
// Parametrised valid/ready pipeline register chain with stall, bubble collapsing and flush.
// Optional one-entry input skid buffer enabled by defining PIPE_SKID_EN.
module pipe_chain #(
   parameter int unsigned      WIDTH    = 64,
   parameter int unsigned      STAGES   = 4,
   parameter logic [WIDTH-1:0] RST_DATA = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   input  logic                          flush,
   output logic [$clog2(STAGES+2)-1:0]   count
);

   localparam int unsigned CW = $clog2(STAGES + 2);
   localparam logic [STAGES-1:0] ONES = '1;

   logic [STAGES-1:0] valid_q;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [STAGES-1:0] rdy;
   logic              s0_valid;
   logic [WIDTH-1:0]  s0_data;
   logic [CW-1:0]     skid_cnt;
   logic [CW-1:0]     cnt;

   // Stage i accepts if the output drains or any hole exists at or below it;
   // written flat over valid_q so the chain has no self-referencing comb loop.
   always_comb begin
      rdy = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         rdy[i] = out_ready | (|(~valid_q & (ONES << i)));
      end
   end

`ifdef PIPE_SKID_EN
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;

   assign in_ready = !rst && !flush && !skid_valid;
   assign s0_valid = skid_valid || (in_valid && in_ready);
   assign s0_data  = skid_valid ? skid_data : in_data;
   assign skid_cnt = CW'(skid_valid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid <= 1'b0;
         skid_data  <= RST_DATA;
      end else if (flush) begin
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (rdy[0]) skid_valid <= 1'b0;
      end else if (in_valid && in_ready && !rdy[0]) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end
`else
   assign in_ready = !rst && !flush && rdy[0];
   assign s0_valid = in_valid && in_ready;
   assign s0_data  = in_data;
   assign skid_cnt = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < STAGES; i++) data_q[i] <= RST_DATA;
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         if (rdy[0]) begin
            valid_q[0] <= s0_valid;
            if (s0_valid) data_q[0] <= s0_data;
         end
         for (int unsigned i = 1; i < STAGES; i++) begin
            if (rdy[i]) begin
               valid_q[i] <= valid_q[i-1];
               if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
         end
      end
   end

   always_comb begin
      cnt = skid_cnt;
      for (int unsigned i = 0; i < STAGES; i++) cnt = cnt + CW'(valid_q[i]);
   end

   assign count     = cnt;
   assign out_valid = valid_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_pipe_chain.sv
// Directed self-checking bench for pipe_chain: a 4-stage 64-bit instance and a 1-stage 8-bit instance.
module tb_pipe_chain;

`ifdef PIPE_SKID_EN
   localparam int CAP = 5;
`else
   localparam int CAP = 4;
`endif
   localparam logic [63:0] RA = 64'h0000_0000_DEAD_BEEF;
   localparam logic [7:0]  RB = 8'h5A;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
   logic [63:0] a_in_data, a_out_data;
   logic [2:0]  a_count;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
   logic [7:0]  b_in_data, b_out_data;
   logic [1:0]  b_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_chain #(.WIDTH(64), .STAGES(4), .RST_DATA(RA)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .flush(a_flush), .count(a_count));

   pipe_chain #(.WIDTH(8), .STAGES(1), .RST_DATA(RB)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .flush(b_flush), .count(b_count));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int m, acc, del;
      rst = 1'b1;
      a_in_valid = 0; a_out_ready = 0; a_flush = 0; a_in_data = '0;
      b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_in_data = '0;
      repeat (2) tick();

      // reset state
      check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_a_count", 64'(a_count), 64'd0);
      check("rst_a_out_data", a_out_data, RA);
      check("rst_a_in_ready", 64'(a_in_ready), 64'd0);
      check("rst_b_out_data", 64'(b_out_data), 64'(RB));
      check("rst_b_count", 64'(b_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_a_in_ready", 64'(a_in_ready), 64'd1);
      tick();

      // streaming 0x10..0x17, beat n accepted at edge n+1, visible after edge n+4
      a_out_ready = 1;
      for (int n = 0; n < 12; n++) begin
         a_in_valid = (n < 8);
         a_in_data  = 64'h10 + 64'(n);
         if (n < 8) check("stream_in_ready", 64'(a_in_ready), 64'd1);
         tick();
         m   = n + 1;
         acc = (m < 8) ? m : 8;
         del = (m < 4) ? 0 : ((m - 4 > 8) ? 8 : m - 4);
         check("stream_out_valid", 64'(a_out_valid), 64'((m >= 4) && (m <= 11)));
         if (m >= 4 && m <= 11) check("stream_out_data", a_out_data, 64'h10 + 64'(m - 4));
         check("stream_count", 64'(a_count), 64'(acc - del));
      end
      a_in_valid = 0;

      // backpressure
      a_out_ready = 0;
      a_in_valid  = 1;
      sent = 0;
      repeat (10) begin
         a_in_data = 64'h20 + 64'(sent);
         if (a_in_ready) sent++;
         tick();
      end
      check("bp_accepted", 64'(sent), 64'(CAP));
      check("bp_in_ready", 64'(a_in_ready), 64'd0);
      check("bp_count", 64'(a_count), 64'(CAP));
      a_in_valid  = 0;
      a_out_ready = 1;
      for (int j = 0; j < CAP; j++) begin
         #1;
         check("drain_valid", 64'(a_out_valid), 64'd1);
         check("drain_data", a_out_data, 64'h20 + 64'(j));
         tick();
      end
      check("drain_empty", 64'(a_out_valid), 64'd0);
      check("drain_count", 64'(a_count), 64'd0);

      // bubble collapse: A, idle, B with out_ready low
      a_out_ready = 0;
      a_in_valid = 1; a_in_data = 64'hA1; tick();
      check("bub_count1", 64'(a_count), 64'd1);
      a_in_valid = 0; tick();
      a_in_valid = 1; a_in_data = 64'hB2; tick();
      check("bub_count3", 64'(a_count), 64'd2);
      a_in_valid = 0; tick();
      check("bub_count4", 64'(a_count), 64'd2);
      tick();
      check("bub_count5", 64'(a_count), 64'd2);
      check("bub_out_valid", 64'(a_out_valid), 64'd1);
      check("bub_out_a", a_out_data, 64'hA1);
      a_out_ready = 1; tick();
      check("bub_out_b", a_out_data, 64'hB2);
      check("bub_out_b_valid", 64'(a_out_valid), 64'd1);
      tick();
      check("bub_empty", 64'(a_count), 64'd0);

      // flush with 3 beats in flight and 0xAA presented
      a_out_ready = 0;
      a_in_valid = 1;
      for (int j = 0; j < 3; j++) begin
         a_in_data = 64'h31 + 64'(j);
         tick();
      end
      check("fl_pre_count", 64'(a_count), 64'd3);
      a_in_data = 64'hAA;
      a_flush = 1;
      #1;
      check("fl_in_ready", 64'(a_in_ready), 64'd0);
      tick();
      a_flush = 0; a_in_valid = 0;
      check("fl_count", 64'(a_count), 64'd0);
      check("fl_out_valid", 64'(a_out_valid), 64'd0);
      a_out_ready = 1;
      repeat (6) begin
         tick();
         check("fl_no_aa", 64'(a_out_valid), 64'd0);
      end

      // asynchronous reset mid-stream
      for (int j = 0; j < 5; j++) begin
         a_in_valid = 1; a_in_data = 64'h40 + 64'(j);
         tick();
      end
      check("ar_pre_valid", 64'(a_out_valid), 64'd1);
      check("ar_pre_data", a_out_data, 64'h41);
      a_in_valid = 0;
      #2 rst = 1'b1;
      #1;
      check("ar_out_valid", 64'(a_out_valid), 64'd0);
      check("ar_count", 64'(a_count), 64'd0);
      check("ar_out_data", a_out_data, RA);
      check("ar_in_ready", 64'(a_in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      a_in_valid = 1; a_in_data = 64'h50; tick();
      a_in_valid = 0; tick(); tick();
      check("ar_resume_gap", 64'(a_out_valid), 64'd0);
      tick();
      check("ar_resume_valid", 64'(a_out_valid), 64'd1);
      check("ar_resume_data", a_out_data, 64'h50);

      // STAGES=1, WIDTH=8
      b_out_ready = 1;
      b_in_valid = 1; b_in_data = 8'h61;
      #1 check("s1_in_ready0", 64'(b_in_ready), 64'd1);
      tick();
      check("s1_vis_valid", 64'(b_out_valid), 64'd1);
      check("s1_vis_data", 64'(b_out_data), 64'h61);
      b_in_data = 8'h62;
      #1 check("s1_in_ready1", 64'(b_in_ready), 64'd1);
      tick();
      check("s1_sustain", 64'(b_out_data), 64'h62);
`ifndef PIPE_SKID_EN
      b_out_ready = 0; b_in_data = 8'h63;
      tick();
      check("s1_hold_data", 64'(b_out_data), 64'h62);
      check("s1_full_ready", 64'(b_in_ready), 64'd0);
      b_out_ready = 1;
      #1 check("s1_release_ready", 64'(b_in_ready), 64'd1);
      tick();
      check("s1_release_data", 64'(b_out_data), 64'h63);
      check("s1_release_count", 64'(b_count), 64'd1);
`endif
      b_in_valid = 0;
      tick();
      check("s1_empty_valid", 64'(b_out_valid), 64'd0);
      check("s1_empty_count", 64'(b_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised multi-stage pipeline register chain with valid/ready flow control, per-stage stall, bubble collapsing and synchronous flush. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latch banks of the core into one reusable block. The datapath carries an opaque payload bus of configurable width through a configurable number of stages. It is the building block for the next core revision, which needs stall, squash and backpressure between units.

## Interface
Parameters:
- WIDTH, default 64: payload width in bits; 64 matches XLEN.
- STAGES, default 4: number of register stages; legal range 1..16.
- RST_DATA, default 0: payload value held in every stage after reset.

Ports:
- clk, input, 1: sole clock; all state updates on its rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: upstream beat present.
- in_ready, output, 1: block accepts a beat this cycle.
- in_data, input, WIDTH: upstream payload.
- out_valid, output, 1: beat present at output.
- out_ready, input, 1: downstream accepts the beat this cycle.
- out_data, output, WIDTH: payload of the oldest beat.
- flush, input, 1: squash every beat in flight.
- count, output, $clog2(STAGES+2): number of valid entries, including the skid entry when present.

## Operation
- State per stage: valid[i] plus data[i]. Stage 0 is nearest the input. Stage STAGES-1 drives out_valid/out_data.
- Transfer rule: a beat moves on a rising edge when valid && ready is high at that interface. This applies at in_*, out_*, and between stages.
- Stage i can accept when !valid[i] || advance[i+1]. The last stage uses out_ready as its advance condition.
- Bubble collapsing: a stalled downstream stage does not block upstream stages while holes exist below them. Beats pack toward the output.
- Payload registers load only when their stage accepts a beat. They hold during stalls. The payload of an empty stage is don't-care, except after reset, when it equals RST_DATA.
- Ordering: strict FIFO. No beat is dropped or duplicated except by flush.
- Flush, synchronous:
  - At the next edge all valid bits and count clear.
  - in_ready is 0 during a flush cycle, so the input is not accepted.
  - out_valid still reflects current state during the flush cycle. A handshake at the output in that cycle counts as delivered.
- count equals the sum of the valid bits. It updates at every edge consistent with the transfers on that edge.
- Reset (rst=1, asynchronous):
  - All valid bits clear and every data[i] becomes RST_DATA.
  - out_valid=0, out_data=RST_DATA, count=0.
  - in_ready=0 while rst is asserted.
  - Reset mid-stream discards all beats immediately, without waiting for a clock edge.
- Reset wins over flush; flush wins over any transfer.

## Timing
- Latency with no stall: a beat accepted at edge E is visible on out_* after edge E+STAGES-1. For STAGES=1 it is visible right after the accepting edge.
- Throughput: one beat per cycle sustained when out_ready=1.
- Capacity: STAGES beats; STAGES+1 with the skid entry.
- in_ready, no skid: combinational function of out_ready and the valid bits; the path runs through the whole chain.
- Simultaneous accept and release with the chain full:
  - Without skid, in_ready=1 when out_ready=1, so a full chain still streams.
  - With skid, the behaviour is defined in Configuration.
- First in_ready=1 occurs in the first cycle after rst deasserts.

## Configuration
- PIPE_SKID_EN defined:
  - Adds a one-entry skid buffer ahead of stage 0.
  - in_ready = !skid_valid, driven straight from a flop. in_ready then has no combinational dependence on out_ready, so the ready path is cut.
  - A beat that arrives when stage 0 cannot accept is parked in the skid entry. It enters stage 0 first on the next advance, preserving order.
  - Latency is unchanged when not stalled. count includes the skid entry.
  - Flush and reset clear the skid entry.
- PIPE_SKID_EN undefined:
  - No skid entry, and in_ready is combinational as described under Timing.
  - count never exceeds STAGES.

## Test plan
- Streaming (STAGES=4, out_ready=1): feed 0x10..0x17 on consecutive cycles.
  - 0x10 is on out_data 3 edges after its accepting edge, i.e. 4 cycles after being presented.
  - The remaining beats follow back-to-back with no gaps.
- Backpressure (out_ready=0 for 10 cycles, in_valid held):
  - Exactly 4 beats are accepted (5 with PIPE_SKID_EN), then in_ready=0 and count=4 (5).
  - After out_ready=1, all beats drain in order with no loss and no duplicates.
- Bubble collapse: send beats A, idle, B with out_ready=0.
  - By the 5th edge, A sits in the last stage and B in the stage behind it.
  - count=2 throughout once both are accepted.
- Flush with 3 beats in flight while in_valid=1 carries 0xAA:
  - After the edge, count=0 and out_valid=0.
  - 0xAA never appears on the output.
- Asynchronous reset mid-stream (assert rst between clock edges):
  - Immediately out_valid=0, count=0 and out_data=RST_DATA, with no clock edge needed.
  - After release, streaming resumes normally.
- Corner case STAGES=1, WIDTH=8:
  - A beat accepted at an edge is visible right after it.
  - Sustained 1 beat/cycle with out_ready=1.
  - A full-and-release on the same edge accepts the new beat.
